// File: rtl/branch_target_predictor_pkg.sv
// rtl/branch_target_predictor_pkg.sv - shared types and helpers for the branch target predictor
// Holds the direction-counter encodings, the entry view type and a clog2 helper.
package cpu_pred_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // Widest tag/target an entry view carries; narrower fields are zero-extended into it.
  localparam int BTB_FIELD_W = 32;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
    logic [1:0]             ctr;
  } btb_entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - fetch lookup and ID training bus of the predictor
// The pipeline is the master; the predictor is the slave.
interface branch_target_predictor_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] if_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic            upd_uncond;
  logic [PC_W-1:0] upd_target;
  logic            upd_mispred;
  logic            flush_all;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_uncond, upd_target, upd_mispred, flush_all,
    input  pred_taken, pred_target
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_uncond, upd_target, upd_mispred, flush_all,
    output pred_taken, pred_target
  );
endinterface

// File: rtl/branch_target_predictor_sat_counter2.sv
// rtl/branch_target_predictor_sat_counter2.sv - 2-bit up/down saturating counter with load
// Load has priority over increment and decrement.
module sat_counter2
  import cpu_pred_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [1:0] i_load_val,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [1:0] o_ctr
);
  logic [1:0] r_ctr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctr <= SNT;
    end else if (i_load) begin
      r_ctr <= i_load_val;
    end else if (i_inc && (r_ctr != ST)) begin
      r_ctr <= r_ctr + 2'd1;
    end else if (i_dec && (r_ctr != SNT)) begin
      r_ctr <= r_ctr - 2'd1;
    end
  end

  assign o_ctr = r_ctr;
endmodule

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with per-entry 2-bit direction counters
// Define BTB_STATS_EN to add the lookup/hit/mispredict statistics counters.
module branch_target_predictor
  import cpu_pred_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  branch_target_predictor_if.slave btb
`ifdef BTB_STATS_EN
  ,
  output logic [STAT_W-1:0]        o_stat_lookups,
  output logic [STAT_W-1:0]        o_stat_hits,
  output logic [STAT_W-1:0]        o_stat_mispred
`endif
);
  localparam int IDX_W = clog2(ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [PC_W-1:0]  r_target [ENTRIES];
  logic [1:0]       w_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx, w_upd_idx;
  logic [TAG_W-1:0] w_lk_tag, w_upd_tag;
  btb_entry_t       w_lk;
  logic             w_lk_hit, w_upd_hit, w_upd_go, w_upd_wr;
  logic             w_ld, w_inc, w_dec;

  assign w_lk_idx  = btb.if_pc[IDX_W+1:2];
  assign w_lk_tag  = btb.if_pc[PC_W-1:IDX_W+2];
  assign w_upd_idx = btb.upd_pc[IDX_W+1:2];
  assign w_upd_tag = btb.upd_pc[PC_W-1:IDX_W+2];

  // Lookup reads only registered state, so a same-cycle update is seen one cycle later.
  always_comb begin
    w_lk        = '0;
    w_lk.valid  = r_valid[w_lk_idx];
    w_lk.tag    = BTB_FIELD_W'(r_tag[w_lk_idx]);
    w_lk.target = BTB_FIELD_W'(r_target[w_lk_idx]);
    w_lk.ctr    = w_ctr[w_lk_idx];
  end

  assign w_lk_hit        = w_lk.valid && (w_lk.tag == BTB_FIELD_W'(w_lk_tag));
  assign btb.pred_taken  = w_lk_hit && (w_lk.ctr >= WT);
  assign btb.pred_target = btb.pred_taken ? PC_W'(w_lk.target) : '0;

  assign w_upd_go  = btb.upd_valid && !btb.flush_all;
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_wr  = w_upd_go && (btb.upd_taken || btb.upd_uncond);
  assign w_ld      = (btb.upd_taken || btb.upd_uncond) && (btb.upd_uncond || !w_upd_hit);
  assign w_inc     = w_upd_hit && !btb.upd_uncond && btb.upd_taken;
  assign w_dec     = w_upd_hit && !btb.upd_uncond && !btb.upd_taken;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (btb.flush_all) begin
      for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
    end else if (w_upd_wr) begin
      r_valid[w_upd_idx]  <= 1'b1;
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= btb.upd_target;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic w_sel;
    assign w_sel = w_upd_go && (w_upd_idx == IDX_W'(g));

    sat_counter2 u_ctr (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_sel && w_ld),
      .i_load_val (btb.upd_uncond ? ST : WT),
      .i_inc      (w_sel && w_inc),
      .i_dec      (w_sel && w_dec),
      .o_ctr      (w_ctr[g])
    );
  end

`ifdef BTB_STATS_EN
  logic [STAT_W-1:0] r_stat_lookups, r_stat_hits, r_stat_mispred;

  // Statistics saturate at all-ones and survive flush_all.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stat_lookups <= '0;
      r_stat_hits    <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (!(&r_stat_lookups)) r_stat_lookups <= r_stat_lookups + STAT_W'(1);
      if (w_lk_hit && !(&r_stat_hits)) r_stat_hits <= r_stat_hits + STAT_W'(1);
      if (btb.upd_valid && btb.upd_mispred && !(&r_stat_mispred))
        r_stat_mispred <= r_stat_mispred + STAT_W'(1);
    end
  end

  assign o_stat_lookups = r_stat_lookups;
  assign o_stat_hits    = r_stat_hits;
  assign o_stat_mispred = r_stat_mispred;

  logic w_unused;
  assign w_unused = ^{btb.if_pc[1:0], btb.upd_pc[1:0]};
`else
  localparam int stat_w_unused = STAT_W;
  logic w_unused;
  assign w_unused = ^{btb.if_pc[1:0], btb.upd_pc[1:0], btb.upd_mispred};
`endif
endmodule
